y86_instr_encoder: RTL
======================

# y86_instr_encoder

Sequential Y86-64 instruction encoder and instruction-memory writer. It takes decoded instruction fields (icode, ifun, rA, rB, valC), serialises them into the byte format that the fetch stage parses, and writes them one byte per clock into instruction memory at an internal write pointer. When an instruction is done, the pointer advances to the next-instruction address (valP). It sits between the program loader or bench and instruction memory, and is used to build programs that the fetch stage then reads back.

## Interface
- MEM_SIZE, 1024: instruction memory size in bytes. Valid addresses are 0..MEM_SIZE-1.
- clk  in  1: clock; all state changes on the rising edge.
- reset  in  1: synchronous, active-high.
- start  in  1: request to encode one instruction; accepted only when ready=1.
- icode  in  4: instruction code.
- ifun  in  4: function code.
- rA  in  4: register A; 0xF means none.
- rB  in  4: register B; 0xF means none.
- valC  in  64: constant word or destination.
- load_pc  in  1: load the write pointer; honoured only when ready=1.
- pc_in  in  64: new write-pointer value.
- ready  out  1: encoder idle; start and load_pc are accepted this cycle.
- mem_we  out  1: byte write strobe.
- mem_addr  out  64: byte address.
- mem_wdata  out  8: byte data.
- done  out  1: one-cycle pulse, coincident with the last byte write.
- enc_error  out  1: one-cycle pulse; illegal icode/ifun, instruction dropped.
- addr_error  out  1: one-cycle pulse; instruction would exceed MEM_SIZE, instruction dropped.
- pc  out  64: current write pointer; after done it equals valP.

## Operation
- Instruction length by icode:
  - 0 (halt), 1 (nop), 9 (ret): 1 byte.
  - 2 (rrmovq/cmovXX), 6 (OPq), A (pushq), B (popq): 2 bytes.
  - 3 (irmovq), 4 (rmmovq), 5 (mrmovq): 10 bytes.
  - 7 (jXX), 8 (call): 9 bytes.
- Byte layout:
  - byte0 = {icode, ifun}.
  - For lengths 2 and 10: byte1 = {rA, rB}.
  - valC is little-endian, starting at byte2 for length 10 and byte1 for length 9.
- Legality: icode > 0xB is illegal. Legal ifun is 0..3 for icode 6 and 0..6 for icodes 2 and 7; every other icode requires ifun = 0. An illegal instruction gets enc_error.
- Bounds: if pc + len > MEM_SIZE, the instruction gets addr_error.
- When both errors apply, enc_error wins and only enc_error pulses.
- On any error: no writes occur and pc is unchanged.
- State machine:
  - IDLE (ready=1):
    - load_pc=1: pc <= pc_in; stay in IDLE. load_pc has priority over start in the same cycle, and that start is ignored.
    - start=1: latch all fields and compute len; go to ERR if illegal or out of range, else EMIT with k=0.
  - EMIT (ready=0):
    - Each cycle: mem_we=1, mem_addr=pc+k, mem_wdata=byte k, then k <= k+1.
    - When k=len-1: done=1, pc <= pc+len, go to IDLE.
  - ERR (ready=0): the appropriate error pulses for one cycle, then go to IDLE.
- Inputs are sampled only at acceptance. Changing icode/valC etc. during EMIT has no effect.
- start or load_pc while ready=0 is ignored; it is not queued.
- Address arithmetic is 64-bit. The bounds check uses a 65-bit sum so that pc near 2^64 cannot wrap past the check.

## Timing
- Reset values: state IDLE, ready=1, pc=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, enc_error=0, addr_error=0, k=0.
- Reset asserted mid-EMIT:
  - Writes stop at that edge; mem_we=0 from the next cycle.
  - pc returns to 0; the partially written bytes stay in memory.
- start accepted at edge T:
  - Bytes are written in cycles T+1..T+len.
  - done is high in cycle T+len; ready=1 from cycle T+len+1.
  - Throughput: one instruction per len+1 cycles.
- Error case: start accepted at edge T; the error pulses in cycle T+1; ready=1 in cycle T+2.
- mem_addr and mem_wdata are registered. They hold their last value when mem_we=0.
- pc updates at the same edge that ends the done cycle.

## Test plan
- **irmovq:** reset, then start icode=3 ifun=0 rA=F rB=3 valC=0x0123456789ABCDEF at pc=0.
  - Required: writes addr 0..9 = 30 F3 EF CD AB 89 67 45 23 01; done in the 10th write cycle; pc=10.
- **Back-to-back halt, nop, ret:** from pc=10.
  - Required: single writes 00@10, 10@11, 90@12; pc=13; each instruction takes 2 cycles from start to ready.
- **call:** load_pc to 0x20, then start icode=8 valC=0x100.
  - Required: writes 80 00 01 00 00 00 00 00 00 at 0x20..0x28; pc=0x29.
- **Illegal encodings:** icode=C; separately icode=6 ifun=4.
  - Required: enc_error pulse, mem_we stays 0, pc unchanged, ready back two cycles after acceptance.
- **Out-of-range:** pc=1020 (MEM_SIZE=1024), start icode=4.
  - Required: addr_error, no writes, pc=1020.
  - Also at pc=1022: icode=2 (len 2) succeeds and pc=1024.
- **Reset and ignored requests:**
  - Reset asserted at the 4th write of irmovq: mem_we low from the next cycle, pc=0, ready=1.
  - start held during EMIT: no second instruction is emitted.

Source files
------------

// File: rtl/y86_instr_encoder.sv
// y86_instr_encoder: serialises decoded Y86-64 instruction fields into the
// fetch-stage byte format and writes them one byte per clock into
// instruction memory at an internal write pointer.
module y86_instr_encoder #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  input  logic        load_pc,
  input  logic [63:0] pc_in,
  output logic        ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        done,
  output logic        enc_error,
  output logic        addr_error,
  output logic [63:0] pc
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  len_q, len_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic        enc_error_q, enc_error_d;
  logic        addr_error_q, addr_error_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d;

  logic [3:0]  in_len;
  logic [64:0] end_sum;
  logic        in_legal;
  logic        in_range;
  logic [3:0]  k_next;

  // Encoded length in bytes for each icode (illegal icodes never reach EMIT)
  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:        instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:  instr_len = 4'd2;
      4'h3, 4'h4, 4'h5:        instr_len = 4'd10;
      4'h7, 4'h8:              instr_len = 4'd9;
      default:                 instr_len = 4'd1;
    endcase
  endfunction

  // icode/ifun legality: OPq has 4 functions, cmov/jump have 7, others only 0
  function automatic logic instr_legal(input logic [3:0] ic, input logic [3:0] fn);
    if (ic > 4'hB)                    instr_legal = 1'b0;
    else if (ic == 4'h6)              instr_legal = (fn <= 4'd3);
    else if (ic == 4'h2 || ic == 4'h7) instr_legal = (fn <= 4'd6);
    else                              instr_legal = (fn == 4'd0);
  endfunction

  // Byte k of the encoding; valC is little-endian after the optional reg byte
  function automatic logic [7:0] instr_byte(input logic [3:0] k, input logic [3:0] len,
                                            input logic [3:0] ic, input logic [3:0] fn,
                                            input logic [3:0] ra, input logic [3:0] rb,
                                            input logic [63:0] vc);
    logic [3:0]  idx;
    logic [63:0] sh;
    idx = (len == 4'd10) ? (k - 4'd2) : (k - 4'd1);
    sh  = vc >> {idx, 3'b000};
    if (k == 4'd0)                                         instr_byte = {ic, fn};
    else if ((len == 4'd2 || len == 4'd10) && k == 4'd1)   instr_byte = {ra, rb};
    else                                                   instr_byte = sh[7:0];
  endfunction

  // Next-state, pointer and registered memory-port computation
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    k_d          = k_q;
    len_d        = len_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = 1'b0;
    enc_error_d  = 1'b0;
    addr_error_d = 1'b0;
    icode_d      = icode_q;
    ifun_d       = ifun_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    valc_d       = valc_q;
    k_next       = k_q + 4'd1;

    in_len   = instr_len(icode);
    in_legal = instr_legal(icode, ifun);
    // 65-bit sum so a pointer near 2^64 cannot wrap under the limit
    end_sum  = {1'b0, pc_q} + {61'd0, in_len};
    in_range = (end_sum <= 65'(MEM_SIZE));

    case (state_q)
      S_IDLE: begin
        if (load_pc) begin
          pc_d = pc_in;
        end else if (start) begin
          icode_d = icode;
          ifun_d  = ifun;
          ra_d    = rA;
          rb_d    = rB;
          valc_d  = valC;
          len_d   = in_len;
          k_d     = 4'd0;
          if (!in_legal) begin
            enc_error_d = 1'b1;
            state_d     = S_ERR;
          end else if (!in_range) begin
            addr_error_d = 1'b1;
            state_d      = S_ERR;
          end else begin
            state_d     = S_EMIT;
            mem_we_d    = 1'b1;
            mem_addr_d  = pc_q;
            mem_wdata_d = {icode, ifun};
            done_d      = (in_len == 4'd1);
          end
        end
      end
      S_EMIT: begin
        if (k_q == len_q - 4'd1) begin
          pc_d    = pc_q + {60'd0, len_q};
          k_d     = 4'd0;
          state_d = S_IDLE;
        end else begin
          k_d         = k_next;
          mem_we_d    = 1'b1;
          mem_addr_d  = pc_q + {60'd0, k_next};
          mem_wdata_d = instr_byte(k_next, len_q, icode_q, ifun_q, ra_q, rb_q, valc_q);
          done_d      = (k_next == len_q - 4'd1);
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and registered outputs, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= 64'd0;
      k_q          <= 4'd0;
      len_q        <= 4'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 64'd0;
      mem_wdata_q  <= 8'd0;
      done_q       <= 1'b0;
      enc_error_q  <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      k_q          <= k_d;
      len_q        <= len_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
      enc_error_q  <= enc_error_d;
      addr_error_q <= addr_error_d;
    end
  end

  // Latched instruction fields; only meaningful while EMIT is active
  always_ff @(posedge clk) begin
    icode_q <= icode_d;
    ifun_q  <= ifun_d;
    ra_q    <= ra_d;
    rb_q    <= rb_d;
    valc_q  <= valc_d;
  end

  assign ready      = (state_q == S_IDLE);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign done       = done_q;
  assign enc_error  = enc_error_q;
  assign addr_error = addr_error_q;
  assign pc         = pc_q;

endmodule
